// File: rtl/serial_uart.sv
// UART receiver: 8N1 framing, LSB first, CLKS_PER_BIT clocks per bit.
// data_out/valid hold the last good byte until the next start bit is seen.
module serial_uart #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       valid,
    output logic [2:0] dbg_state_o
);

    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int CW   = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [2:0]    bit_q,   bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q,  data_d;
    logic          valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;

        case (state_q)
            IDLE: begin
                if (!serial_in) begin
                    valid_d = 1'b0;
                    bit_d   = 3'd0;
                    cnt_d   = CNT_ONE;
                    // With no mid-bit offset the start check is this very edge.
                    if (HALF == 0) begin
                        state_d = DATA;
                    end else begin
                        state_d = START;
                    end
                end
            end

            START: begin
                if (cnt_q == CNT_HALF) begin
                    if (serial_in) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = DATA;
                        cnt_d   = CNT_ONE;
                        bit_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            DATA: begin
                if (cnt_q == CNT_BIT) begin
                    shift_d[bit_q] = serial_in;
                    cnt_d          = CNT_ONE;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            STOP: begin
                if (cnt_q == CNT_BIT) begin
                    cnt_d = '0;
                    if (serial_in) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // Framing error: drop the byte and wait for a high line.
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            WAIT_IDLE: begin
                if (serial_in) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                bit_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out    = data_q;
    assign valid       = valid_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_uart.sv
// Directed bench for serial_uart: one instance at 1 clock/bit, one at 4 clocks/bit.
// Inputs change on the falling edge; outputs are checked on the falling edge after each rising edge.
module tb_serial_uart;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd4;

    logic       clk = 1'b0;
    logic       reset;
    logic       line1, line4;
    logic [7:0] data1, data4;
    logic       valid1, valid4;
    logic [2:0] st1, st4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_uart #(.CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .reset(reset), .serial_in(line1),
        .data_out(data1), .valid(valid1), .dbg_state_o(st1)
    );

    serial_uart #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk(clk), .reset(reset), .serial_in(line4),
        .data_out(data4), .valid(valid4), .dbg_state_o(st4)
    );

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         low_after;
        int         gap_after;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [2:0] exp_state;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) line4 = v;
        else     line1 = v;
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop);
        int         cpb;
        logic [9:0] bits;
        cpb  = sel ? 4 : 1;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < cpb; j++) begin
                drive(sel, bits[i]);
                @(negedge clk);
                if (i == 0 && j == 0)
                    chk("valid_clear_at_start", {7'd0, sel ? valid4 : valid1}, 8'h00);
            end
        end
    endtask

    initial begin
        // stop edge expectations, then optional low hold and idle gap
        tbl[0] = '{8'hAB, 1'b1, 0, 5, 1'b1, 8'hAB, S_IDLE};
        tbl[1] = '{8'h55, 1'b1, 0, 0, 1'b1, 8'h55, S_IDLE};
        tbl[2] = '{8'h00, 1'b1, 0, 2, 1'b1, 8'h00, S_IDLE};
        tbl[3] = '{8'h12, 1'b1, 0, 1, 1'b1, 8'h12, S_IDLE};
        tbl[4] = '{8'h3C, 1'b0, 3, 1, 1'b0, 8'h12, S_WAIT};
        tbl[5] = '{8'hA5, 1'b1, 0, 2, 1'b1, 8'hA5, S_IDLE};
        tbl[6] = '{8'hC7, 1'b1, 0, 3, 1'b1, 8'hC7, S_IDLE};

        reset = 1'b0;
        line1 = 1'b1;
        line4 = 1'b1;

        // Reset held with the lines toggling
        for (int i = 0; i < 6; i++) begin
            line1 = i[0];
            line4 = ~i[0];
            @(negedge clk);
            chk("rst_valid1", {7'd0, valid1}, 8'h00);
            chk("rst_data1",  data1, 8'h00);
            chk("rst_valid4", {7'd0, valid4}, 8'h00);
            chk("rst_data4",  data4, 8'h00);
        end
        chk("rst_state1", {5'd0, st1}, {5'd0, S_IDLE});
        line1 = 1'b1;
        line4 = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven frames on the 1 clock/bit instance
        for (int t = 0; t < 7; t++) begin
            send_frame(1'b0, tbl[t].data, tbl[t].stop);
            chk($sformatf("tbl%0d_valid", t), {7'd0, valid1}, {7'd0, tbl[t].exp_valid});
            chk($sformatf("tbl%0d_data", t),  data1, tbl[t].exp_data);
            chk($sformatf("tbl%0d_state", t), {5'd0, st1}, {5'd0, tbl[t].exp_state});
            for (int i = 0; i < tbl[t].low_after; i++) begin
                line1 = 1'b0;
                @(negedge clk);
            end
            if (tbl[t].low_after > 0) begin
                chk($sformatf("tbl%0d_low_state", t), {5'd0, st1}, {5'd0, S_WAIT});
                chk($sformatf("tbl%0d_low_valid", t), {7'd0, valid1}, {7'd0, tbl[t].exp_valid});
            end
            for (int i = 0; i < tbl[t].gap_after; i++) begin
                line1 = 1'b1;
                @(negedge clk);
            end
            if (tbl[t].gap_after > 0) begin
                chk($sformatf("tbl%0d_gap_state", t), {5'd0, st1}, {5'd0, S_IDLE});
                chk($sformatf("tbl%0d_gap_valid", t), {7'd0, valid1}, {7'd0, tbl[t].exp_valid});
                chk($sformatf("tbl%0d_gap_data", t),  data1, tbl[t].exp_data);
            end
        end

        // Reset mid-frame: start bit plus four data bits of 0xFF
        line1 = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            line1 = 1'b1;
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        chk("midrst_valid", {7'd0, valid1}, 8'h00);
        chk("midrst_data",  data1, 8'h00);
        chk("midrst_state", {5'd0, st1}, {5'd0, S_IDLE});
        @(negedge clk);
        reset = 1'b1;
        // Start bit on the first edge after release must be taken
        send_frame(1'b0, 8'h81, 1'b1);
        chk("post_rst_valid", {7'd0, valid1}, 8'h01);
        chk("post_rst_data",  data1, 8'h81);
        line1 = 1'b1;
        repeat (2) @(negedge clk);

        // 4 clocks/bit: glitch while nothing received yet
        line4 = 1'b0;
        @(negedge clk);
        chk("glitch0_state_start", {5'd0, st4}, {5'd0, S_START});
        line4 = 1'b1;
        @(negedge clk);
        chk("glitch0_state", {5'd0, st4}, {5'd0, S_IDLE});
        repeat (3) @(negedge clk);
        chk("glitch0_valid", {7'd0, valid4}, 8'h00);
        chk("glitch0_data",  data4, 8'h00);

        send_frame(1'b1, 8'h5A, 1'b1);
        chk("os_5a_valid", {7'd0, valid4}, 8'h01);
        chk("os_5a_data",  data4, 8'h5A);
        line4 = 1'b1;
        repeat (3) @(negedge clk);

        // Glitch after a good byte leaves data_out alone
        line4 = 1'b0;
        @(negedge clk);
        line4 = 1'b1;
        repeat (4) @(negedge clk);
        chk("glitch1_state", {5'd0, st4}, {5'd0, S_IDLE});
        chk("glitch1_data",  data4, 8'h5A);

        send_frame(1'b1, 8'hC3, 1'b1);
        chk("os_c3_valid", {7'd0, valid4}, 8'h01);
        chk("os_c3_data",  data4, 8'hC3);

        // Framing error at 4 clocks/bit, then recovery
        send_frame(1'b1, 8'h66, 1'b0);
        chk("os_ferr_valid", {7'd0, valid4}, 8'h00);
        chk("os_ferr_data",  data4, 8'hC3);
        chk("os_ferr_state", {5'd0, st4}, {5'd0, S_WAIT});
        line4 = 1'b1;
        @(negedge clk);
        send_frame(1'b1, 8'h3E, 1'b1);
        chk("os_3e_valid", {7'd0, valid4}, 8'h01);
        chk("os_3e_data",  data4, 8'h3E);
        line4 = 1'b1;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
